// File: rtl/stopwatch_timer_dp.sv
// stopwatch_timer_dp: parametrised up/down stopwatch-timer datapath with preset load and lap capture
module stopwatch_timer_dp #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 100,
    parameter int HOUR_MAX = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       clear,
    input  logic       mode_down,
    input  logic       load,
    input  logic [6:0] pre_msec,
    input  logic [5:0] pre_sec,
    input  logic [5:0] pre_min,
    input  logic [4:0] pre_hour,
    input  logic       lap_capture,
    output logic [6:0] msec,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [6:0] lap_msec,
    output logic [5:0] lap_sec,
    output logic [5:0] lap_min,
    output logic [4:0] lap_hour,
    output logic       lap_valid,
    output logic       tick,
    output logic       wrap,
    output logic       expired
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PSC_TOP = PW'(DIV - 1);
    localparam logic [6:0] MS_TOP = 7'(TICK_HZ - 1);
    localparam logic [4:0] HR_TOP = 5'(HOUR_MAX - 1);

    logic [PW-1:0] psc_q, psc_d;
    logic [6:0] msec_q, msec_d, lap_msec_q;
    logic [5:0] sec_q, sec_d, lap_sec_q;
    logic [5:0] min_q, min_d, lap_min_q;
    logic [4:0] hour_q, hour_d, lap_hour_q;
    logic expired_q, expired_d, lap_valid_q, tick_q, wrap_q;
    logic adv, tick_en, wrap_en, all_zero;
    logic m_top, s_top, mi_top, h_top, m_z, s_z, mi_z;

    // clear and load own the cycle, so the prescaler only advances when neither is present
    assign adv      = run & ~expired_q & ~clear & ~load;
    assign tick_en  = adv & (psc_q == PSC_TOP);
    assign m_top    = msec_q == MS_TOP;
    assign s_top    = sec_q == 6'd59;
    assign mi_top   = min_q == 6'd59;
    assign h_top    = hour_q == HR_TOP;
    assign m_z      = msec_q == '0;
    assign s_z      = sec_q == '0;
    assign mi_z     = min_q == '0;
    assign all_zero = m_z & s_z & mi_z & (hour_q == '0);
    assign wrap_en  = tick_en & ~mode_down & m_top & s_top & mi_top & h_top;

    // next-state for prescaler, the four time fields and the expiry flag
    always_comb begin
        psc_d     = psc_q;
        msec_d    = msec_q;
        sec_d     = sec_q;
        min_d     = min_q;
        hour_d    = hour_q;
        expired_d = expired_q;
        if (clear) begin
            psc_d     = '0;
            msec_d    = '0;
            sec_d     = '0;
            min_d     = '0;
            hour_d    = '0;
            expired_d = 1'b0;
        end else if (load) begin
            psc_d     = '0;
            msec_d    = (pre_msec > MS_TOP) ? MS_TOP : pre_msec;
            sec_d     = (pre_sec > 6'd59) ? 6'd59 : pre_sec;
            min_d     = (pre_min > 6'd59) ? 6'd59 : pre_min;
            hour_d    = (pre_hour > HR_TOP) ? HR_TOP : pre_hour;
            expired_d = 1'b0;
        end else if (tick_en) begin
            psc_d = '0;
            if (mode_down && all_zero) begin
                expired_d = 1'b1;
            end else if (mode_down) begin
                msec_d = m_z ? MS_TOP : msec_q - 7'd1;
                sec_d  = m_z ? (s_z ? 6'd59 : sec_q - 6'd1) : sec_q;
                min_d  = (m_z & s_z) ? (mi_z ? 6'd59 : min_q - 6'd1) : min_q;
                hour_d = (m_z & s_z & mi_z) ? hour_q - 5'd1 : hour_q;
            end else begin
                msec_d = m_top ? '0 : msec_q + 7'd1;
                sec_d  = m_top ? (s_top ? '0 : sec_q + 6'd1) : sec_q;
                min_d  = (m_top & s_top) ? (mi_top ? '0 : min_q + 6'd1) : min_q;
                hour_d = (m_top & s_top & mi_top) ? (h_top ? '0 : hour_q + 5'd1) : hour_q;
            end
        end else if (adv) begin
            psc_d = psc_q + 1'b1;
        end
    end

    // datapath registers; all fields commit on the same edge so the display never tears
    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q     <= '0;
            msec_q    <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            psc_q     <= psc_d;
            msec_q    <= msec_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            expired_q <= expired_d;
            tick_q    <= tick_en;
            wrap_q    <= wrap_en;
        end
    end

    // lap snapshot takes the pre-edge field values, independent of clear/load
    always_ff @(posedge clk) begin
        if (reset) begin
            lap_msec_q  <= '0;
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
            lap_hour_q  <= '0;
            lap_valid_q <= 1'b0;
        end else if (lap_capture) begin
            lap_msec_q  <= msec_q;
            lap_sec_q   <= sec_q;
            lap_min_q   <= min_q;
            lap_hour_q  <= hour_q;
            lap_valid_q <= 1'b1;
        end
    end

    assign msec      = msec_q;
    assign sec       = sec_q;
    assign min       = min_q;
    assign hour      = hour_q;
    assign lap_msec  = lap_msec_q;
    assign lap_sec   = lap_sec_q;
    assign lap_min   = lap_min_q;
    assign lap_hour  = lap_hour_q;
    assign lap_valid = lap_valid_q;
    assign tick      = tick_q;
    assign wrap      = wrap_q;
    assign expired   = expired_q;
endmodule

// File: tb/tb_stopwatch_timer_dp.sv
// tb_stopwatch_timer_dp: directed checks of the stopwatch/timer datapath (DIV=10, HOUR_MAX 24 and 2)
module tb_stopwatch_timer_dp;
    logic clk = 1'b0;
    logic reset, run, clear, mode_down, load, lap_capture;
    logic [6:0] pre_msec;
    logic [5:0] pre_sec, pre_min;
    logic [4:0] pre_hour;
    logic [6:0] msec, lap_msec, msec2, lap_msec2;
    logic [5:0] sec, min, lap_sec, lap_min, sec2, min2, lap_sec2, lap_min2;
    logic [4:0] hour, lap_hour, hour2, lap_hour2;
    logic lap_valid, tick, wrap, expired, lap_valid2, tick2, wrap2, expired2;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stopwatch_timer_dp #(.CLK_HZ(1000), .TICK_HZ(100), .HOUR_MAX(24)) dut (
        .clk(clk), .reset(reset), .run(run), .clear(clear), .mode_down(mode_down), .load(load),
        .pre_msec(pre_msec), .pre_sec(pre_sec), .pre_min(pre_min), .pre_hour(pre_hour),
        .lap_capture(lap_capture), .msec(msec), .sec(sec), .min(min), .hour(hour),
        .lap_msec(lap_msec), .lap_sec(lap_sec), .lap_min(lap_min), .lap_hour(lap_hour),
        .lap_valid(lap_valid), .tick(tick), .wrap(wrap), .expired(expired)
    );

    stopwatch_timer_dp #(.CLK_HZ(1000), .TICK_HZ(100), .HOUR_MAX(2)) dut2 (
        .clk(clk), .reset(reset), .run(run), .clear(clear), .mode_down(mode_down), .load(load),
        .pre_msec(pre_msec), .pre_sec(pre_sec), .pre_min(pre_min), .pre_hour(pre_hour),
        .lap_capture(lap_capture), .msec(msec2), .sec(sec2), .min(min2), .hour(hour2),
        .lap_msec(lap_msec2), .lap_sec(lap_sec2), .lap_min(lap_min2), .lap_hour(lap_hour2),
        .lap_valid(lap_valid2), .tick(tick2), .wrap(wrap2), .expired(expired2)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic preset(input int ms, input int s, input int m, input int h);
        pre_msec = 7'(ms);
        pre_sec  = 6'(s);
        pre_min  = 6'(m);
        pre_hour = 5'(h);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; clear = 1'b0; mode_down = 1'b0; load = 1'b0; lap_capture = 1'b0;
        preset(0, 0, 0, 0);
        step(2);
        check("rst_msec", 32'(msec), 0);
        check("rst_sec", 32'(sec), 0);
        check("rst_hour", 32'(hour), 0);
        check("rst_lap_valid", 32'(lap_valid), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_expired", 32'(expired), 0);
        reset = 1'b0;
        run = 1'b1;
        step(9);
        check("pre_msec9", 32'(msec), 0);
        check("pre_tick9", 32'(tick), 0);
        step(1);
        check("pre_msec10", 32'(msec), 1);
        check("pre_tick10", 32'(tick), 1);
        step(1);
        check("pre_tick11", 32'(tick), 0);
        step(989);
        check("pre_msec1000", 32'(msec), 0);
        check("pre_sec1000", 32'(sec), 1);
        check("pre_tick1000", 32'(tick), 1);

        run = 1'b0; load = 1'b1; preset(99, 59, 59, 1);
        step(1);
        load = 1'b0;
        check("ld_msec2", 32'(msec2), 99);
        check("ld_hour2", 32'(hour2), 1);
        run = 1'b1;
        step(9);
        check("roll_msec_before", 32'(msec2), 99);
        check("roll_wrap_before", 32'(wrap2), 0);
        step(1);
        check("roll_msec", 32'(msec2), 0);
        check("roll_sec", 32'(sec2), 0);
        check("roll_min", 32'(min2), 0);
        check("roll_hour", 32'(hour2), 0);
        check("roll_wrap", 32'(wrap2), 1);
        check("h24_hour", 32'(hour), 2);
        check("h24_wrap", 32'(wrap), 0);
        step(1);
        check("roll_wrap_drop", 32'(wrap2), 0);

        run = 1'b0; mode_down = 1'b1; load = 1'b1; preset(0, 1, 0, 0);
        step(1);
        load = 1'b0; run = 1'b1;
        step(10);
        check("dn_msec99", 32'(msec), 99);
        check("dn_sec0", 32'(sec), 0);
        step(990);
        check("dn_zero_msec", 32'(msec), 0);
        check("dn_zero_sec", 32'(sec), 0);
        check("dn_zero_exp", 32'(expired), 0);
        step(10);
        check("dn_exp", 32'(expired), 1);
        check("dn_exp_msec", 32'(msec), 0);
        step(20);
        check("dn_exp_hold", 32'(expired), 1);
        check("dn_exp_msec_hold", 32'(msec), 0);
        check("dn_exp_sec_hold", 32'(sec), 0);

        load = 1'b1; preset(5, 63, 0, 31);
        step(1);
        load = 1'b0;
        check("clamp_sec", 32'(sec), 59);
        check("clamp_hour", 32'(hour), 23);
        check("clamp_hour2", 32'(hour2), 1);
        check("clamp_msec", 32'(msec), 5);
        check("reload_exp", 32'(expired), 0);
        step(10);
        check("resume_msec", 32'(msec), 4);

        run = 1'b0; load = 1'b1; preset(127, 0, 0, 0);
        step(1);
        check("clamp_msec127", 32'(msec), 99);
        clear = 1'b1; load = 1'b1; preset(7, 8, 9, 3);
        step(1);
        load = 1'b0;
        check("clr_ld_msec", 32'(msec), 0);
        check("clr_ld_sec", 32'(sec), 0);
        check("clr_ld_hour", 32'(hour), 0);
        run = 1'b1;
        step(25);
        check("clr_held_msec", 32'(msec), 0);
        check("lap_valid_none", 32'(lap_valid), 0);
        clear = 1'b0; run = 1'b0; mode_down = 1'b0; load = 1'b1; preset(42, 5, 0, 0);
        step(1);
        load = 1'b0; lap_capture = 1'b1; clear = 1'b1;
        step(1);
        lap_capture = 1'b0; clear = 1'b0;
        check("lap_msec", 32'(lap_msec), 42);
        check("lap_sec", 32'(lap_sec), 5);
        check("lap_valid", 32'(lap_valid), 1);
        check("lapclr_msec", 32'(msec), 0);
        check("lapclr_sec", 32'(sec), 0);
        step(3);
        check("lap_hold", 32'(lap_msec), 42);

        load = 1'b1; run = 1'b1; preset(3, 2, 1, 0);
        step(1);
        load = 1'b0;
        check("mid_min", 32'(min), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("mid_rst_msec", 32'(msec), 0);
        check("mid_rst_min", 32'(min), 0);
        check("mid_rst_lap_valid", 32'(lap_valid), 0);
        check("mid_rst_lap_msec", 32'(lap_msec), 0);
        step(9);
        check("mid_msec9", 32'(msec), 0);
        step(1);
        check("mid_msec10", 32'(msec), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
